acia_6502_bus: RTL and testbench

// Serial port responder on the 6502 CPU bus: the peripheral end of the CPU's read/write cycles,

---
 rtl/acia_6502_bus.sv | 171 +++++++++++++++++
 tb/tb_acia_6502_bus.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_6502_bus.sv
// acia_6502_bus: 8N1 serial port on the 6502 bus with a status/control register, a data register and a level IRQ.
// The TX side is a holding register feeding a shifter; the RX side is a 2-flop synchronised, mid-bit-sampling receiver.
module acia_6502_bus #(
    parameter int BAUD_DIV = 35
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       rx,
    output logic       tx
);
    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0] tx_hold_q, tx_hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d, dout_q, dout_d, status;
    logic tx_q, tx_d, tx_empty_q, tx_empty_d, rx_full_q, rx_full_d;
    logic oe_q, oe_d, fe_q, fe_d, rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d;
    logic rx_m_q, rx_s_q, rx_p_q;
    logic rd, rd_data, wr_ctrl, wr_data, clr, load, tick, rtick, rx_done, fe_set, oe_set;
    always_comb begin
        rd = cs & ~we;
        rd_data = rd & rs;
        wr_ctrl = cs & we & ~rs;
        wr_data = cs & we & rs;
        clr = wr_ctrl & din[0];
        status = {irq_q, 3'b0, fe_q, oe_q, tx_empty_q, rx_full_q};
        dout_d = rd ? (rs ? rx_data_q : status) : dout_q;
        rxie_d = wr_ctrl ? din[7] : rxie_q;
        txie_d = wr_ctrl ? din[6] : txie_q;
        irq_d = (rx_full_q & rxie_q) | (tx_empty_q & txie_q);
    end
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d = tx_sh_q;
        tx_hold_d = wr_data && tx_empty_q ? din : tx_hold_q;
        tx_empty_d = tx_empty_q & ~wr_data;
        tx_d = tx_q;
        load = 1'b0;
        tick = tx_cnt_q == BIT_END;
        if (tx_state_q != IDLE) tx_cnt_d = tick ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            IDLE: load = ~tx_empty_q;
            START: if (tick) begin
                tx_state_d = DATA;
                tx_d = tx_sh_q[0];
            end
            DATA: if (tick) begin
                tx_sh_d = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 1'b1;
                tx_state_d = tx_bit_q == 3'd7 ? STOP : DATA;
                tx_d = tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
            end
            default: if (tick) begin
                tx_state_d = IDLE;
                tx_d = 1'b1;
                load = ~tx_empty_q;
            end
        endcase
        // The holding register is only emptied here, so a write and a load never coincide.
        if (load) begin
            tx_state_d = START;
            tx_sh_d = tx_hold_q;
            tx_empty_d = 1'b1;
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_d = 1'b0;
        end
    end
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_done = 1'b0;
        fe_set = 1'b0;
        rtick = rx_cnt_q == BIT_END;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                rx_state_d = rx_p_q & ~rx_s_q ? START : IDLE;
            end
            START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (rtick) begin
                rx_cnt_d = '0;
                rx_sh_d = {rx_s_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                rx_state_d = rx_bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (rtick) begin
                rx_cnt_d = '0;
                rx_done = 1'b1;
                fe_set = ~rx_s_q;
                rx_state_d = IDLE;
            end
        endcase
        // A read landing on the completion cycle frees the register just in time.
        oe_set = rx_done & rx_full_q & ~rd_data;
        oe_d = oe_set | (oe_q & ~clr);
        fe_d = fe_set | (fe_q & ~clr);
        rx_data_d = rx_done & ~oe_set ? rx_sh_q : rx_data_q;
        rx_full_d = (rx_done & ~oe_set) | (rx_full_q & ~rd_data);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_bit_q <= '0;
            rx_bit_q <= '0;
            tx_hold_q <= '0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_data_q <= '0;
            dout_q <= '0;
            tx_q <= 1'b1;
            tx_empty_q <= 1'b1;
            rx_full_q <= 1'b0;
            oe_q <= 1'b0;
            fe_q <= 1'b0;
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            irq_q <= 1'b0;
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_bit_q <= tx_bit_d;
            rx_bit_q <= rx_bit_d;
            tx_hold_q <= tx_hold_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_data_q <= rx_data_d;
            dout_q <= dout_d;
            tx_q <= tx_d;
            tx_empty_q <= tx_empty_d;
            rx_full_q <= rx_full_d;
            oe_q <= oe_d;
            fe_q <= fe_d;
            rxie_q <= rxie_d;
            txie_q <= txie_d;
            irq_q <= irq_d;
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            rx_p_q <= rx_s_q;
        end
    end
    assign dout = dout_q;
    assign irq = irq_q;
    assign tx = tx_q;
endmodule

// File: tb/tb_acia_6502_bus.sv
// tb_acia_6502_bus: bench for the 6502-bus serial port at 4 clocks per bit.
// A serial line model drives rx and decodes tx; a flag-level model predicts STATUS and RXDATA.
module tb_acia_6502_bus;
    logic clk = 1'b0, reset = 1'b1, cs = 1'b0, we = 1'b0, rs = 1'b0, rx = 1'b1;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic irq, tx;
    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] tx_got[$];
    int tx_cyc[$];

    acia_6502_bus #(.BAUD_DIV(4)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .din(din),
        .dout(dout), .irq(irq), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Serial decoder: mid-bit sampling of every frame seen on tx.
    initial begin
        logic [7:0] mb;
        int ms;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ms = cyc;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    mb[i] = tx;
                end
                repeat (4) @(negedge clk);
                tx_got.push_back(mb);
                tx_cyc.push_back(ms);
            end
        end
    end

    task automatic bus_write(input logic r, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; rs = r; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic r, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; rs = r;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (4) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && tx_got.size() < n; i++) @(negedge clk);
        checks++;
        if (tx_got.size() < n) begin
            errors++;
            $display("FAIL tx_wait: got %0d frames expected %0d", tx_got.size(), n);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL reset_status: got %h expected 02", d); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b expected 1", tx); end
    endtask

    task automatic test_tx_single;
        logic [9:0] f;
        int bad;
        f = {1'b1, 8'hA5, 1'b0};
        bad = 0;
        bus_write(1'b1, 8'hA5);
        cs = 1'b1; we = 1'b0; rs = 1'b0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (dout !== 8'h00) begin errors++; $display("FAIL tx_empty_busy: got %h expected 00", dout); end
            end
            if (i == 1) begin
                cs = 1'b0;
                checks++;
                if (dout !== 8'h02) begin errors++; $display("FAIL tx_empty_after: got %h expected 02", dout); end
            end
            if (tx !== (i < 40 ? f[i/4] : 1'b1)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tx_waveform: got %0d wrong samples expected 0", bad); end
        wait_tx(1);
        if (tx_got.size() > 0) begin
            checks++;
            if (tx_got[0] !== 8'hA5) begin errors++; $display("FAIL tx_single_byte: got %h expected a5", tx_got[0]); end
        end
        tx_got.delete(); tx_cyc.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic seen;
        seen = 1'b0;
        bus_write(1'b1, 8'h55);
        for (int i = 0; i < 20 && !seen; i++) begin
            bus_read(1'b0, d);
            seen = d[1];
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_tx_empty: got 0 expected 1"); end
        bus_write(1'b1, 8'h0F);
        bus_write(1'b1, 8'hFF);
        wait_tx(2);
        repeat (60) @(negedge clk);
        checks++;
        if (tx_got.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", tx_got.size()); end
        if (tx_got.size() >= 2) begin
            checks++;
            if (tx_got[0] !== 8'h55 || tx_got[1] !== 8'h0F) begin
                errors++; $display("FAIL b2b_bytes: got %h %h expected 55 0f", tx_got[0], tx_got[1]);
            end
            checks++;
            if (tx_cyc[1] - tx_cyc[0] != 40) begin
                errors++; $display("FAIL b2b_gap: got %0d expected 40", tx_cyc[1] - tx_cyc[0]);
            end
        end
        tx_got.delete(); tx_cyc.delete();
    endtask

    task automatic test_rx_irq;
        logic [7:0] d;
        bus_write(1'b0, 8'h80);
        send_frame(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h83) begin errors++; $display("FAIL rx_status: got %h expected 83", d); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3c", d); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
        bus_write(1'b0, 8'h00);
        checks++;
        if (dout !== 8'h3C) begin errors++; $display("FAIL dout_hold: got %h expected 3c", dout); end
    endtask

    task automatic test_rx_errors;
        logic [7:0] d;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL overrun_status: got %h expected 07", d); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h11) begin errors++; $display("FAIL overrun_data: got %h expected 11", d); end
        send_frame(8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL framing_status: got %h expected 0f", d); end
        bus_write(1'b0, 8'h01);
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL err_clear: got %h expected 03", d); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL framing_data: got %h expected 5a", d); end
    endtask

    task automatic test_edge_cases;
        logic [7:0] d;
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (60) @(negedge clk);
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL glitch_status: got %h expected 02", d); end
        send_frame(8'h77, 1'b1);
        repeat (2) @(negedge clk);
        send_frame(8'h99, 1'b1);
        cs = 1'b1; we = 1'b0; rs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL coincident_status: got %h expected 03", d); end
        bus_read(1'b1, d);
        checks++;
        if (d !== 8'h99) begin errors++; $display("FAIL coincident_data: got %h expected 99", d); end
        bus_write(1'b1, 8'h00);
        repeat (15) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_abort_tx: got %b expected 1", tx); end
        reset = 1'b0;
        bus_read(1'b0, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL reset_abort_status: got %h expected 02", d); end
        repeat (60) @(negedge clk);
        tx_got.delete(); tx_cyc.delete();
        repeat (60) @(negedge clk);
        checks++;
        if (tx_got.size() != 0) begin errors++; $display("FAIL reset_no_resume: got %0d frames expected 0", tx_got.size()); end
    endtask

    task automatic test_random_rx;
        logic [7:0] d, b, ctrl, m_data, exp_s;
        logic m_full, m_oe, m_fe, stop_bit;
        m_full = 1'b0; m_oe = 1'b0; m_fe = 1'b0; m_data = 8'h99;
        for (int n = 0; n < 10; n++) begin
            ctrl = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'b0, 1'($urandom_range(0, 1))};
            bus_write(1'b0, ctrl);
            if (ctrl[0]) begin m_oe = 1'b0; m_fe = 1'b0; end
            b = 8'($urandom);
            stop_bit = $urandom_range(0, 3) != 0;
            send_frame(b, stop_bit);
            if (!m_full) begin m_data = b; m_full = 1'b1; end
            else m_oe = 1'b1;
            if (!stop_bit) m_fe = 1'b1;
            repeat (2) @(negedge clk);
            exp_s = {(m_full & ctrl[7]) | ctrl[6], 3'b0, m_fe, m_oe, 1'b1, m_full};
            bus_read(1'b0, d);
            checks++;
            if (d !== exp_s) begin errors++; $display("FAIL rand_status[%0d]: got %h expected %h", n, d, exp_s); end
            if ($urandom_range(0, 1) == 1) begin
                bus_read(1'b1, d);
                m_full = 1'b0;
                checks++;
                if (d !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, d, m_data); end
            end
        end
        bus_write(1'b0, 8'h01);
        bus_read(1'b1, d);
    endtask

    task automatic test_random_tx;
        logic [7:0] b;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            bus_write(1'b1, b);
            wait_tx(1);
            if (tx_got.size() > 0) begin
                checks++;
                if (tx_got[0] !== b) begin errors++; $display("FAIL rand_tx[%0d]: got %h expected %h", n, tx_got[0], b); end
            end
            repeat (10) @(negedge clk);
            tx_got.delete(); tx_cyc.delete();
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_irq();
        test_rx_errors();
        test_edge_cases();
        test_random_rx();
        test_random_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
